// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID-stage hazard detector, stall sequencer and stall/flush event counters
//
// Purpose: detects operands the forwarding unit cannot yet supply to EX or to
// the ID-stage branch/jump comparator, and holds the front of the pipeline
// until they reach EX/MEM or MEM/WB. Counts stall and flush cycles.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   IF_ID_Rs, IF_ID_Rt        source register fields of the instruction in ID
//   UsesRt                    ID instruction reads rt
//   PCWriteCond, Jump         ID instruction is a branch / rs-reading jump
//   BranchTaken               comparator resolved a taken branch or jump
//   ID_EX_Rt, ID_EX_Rd        load / ALU destination of the instruction in EX
//   ID_EX_MemRead             EX instruction is a load
//   ID_EX_RegWrite            EX instruction writes the register file
//   EX_MEM_Rd, EX_MEM_MemRead destination and load flag of the MEM instruction
//   PCWrite, IF_ID_Write      front-end update enables
//   ID_EX_Bubble              zero the ID/EX control fields
//   IF_ID_Flush               clear IF/ID to a NOP
//   Stalling                  stall asserted this cycle
//   stall_cnt, flush_cnt      saturating event counters

module hazard_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             UsesRt,
  input  logic [3:0]       PCWriteCond,
  input  logic [1:0]       Jump,
  input  logic             BranchTaken,
  input  logic [4:0]       ID_EX_Rt,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic             EX_MEM_MemRead,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             Stalling,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    HOLD1 = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic ctrl;
  logic rd_rs;
  logic rd_rt;
  logic match_lu;
  logic match_ba;
  logic match_bl;
  logic lu;
  logic ba;
  logic bl;
  logic stall;
  logic flush;

  // Source-operand qualification. A pure jump (no branch condition) feeds
  // only rs to the comparator, so rt cannot create a hazard for it.
  always_comb begin
    ctrl  = (PCWriteCond != 4'd0) || (Jump != 2'd0);
    rd_rs = (IF_ID_Rs != 5'd0);
    rd_rt = UsesRt && (IF_ID_Rt != 5'd0) && !(ctrl && (PCWriteCond == 4'd0));
  end

  always_comb begin
    match_lu = (rd_rs && (ID_EX_Rt  == IF_ID_Rs)) || (rd_rt && (ID_EX_Rt  == IF_ID_Rt));
    match_ba = (rd_rs && (ID_EX_Rd  == IF_ID_Rs)) || (rd_rt && (ID_EX_Rd  == IF_ID_Rt));
    match_bl = (rd_rs && (EX_MEM_Rd == IF_ID_Rs)) || (rd_rt && (EX_MEM_Rd == IF_ID_Rt));
  end

  // Hazard terms:
  //   lu - load in EX feeding any consumer in ID
  //   ba - ALU result in EX feeding the ID comparator (no EX->ID forward path)
  //   bl - load in MEM feeding the ID comparator (data not yet in MEM/WB)
  always_comb begin
    lu = ID_EX_MemRead && (ID_EX_Rt != 5'd0) && match_lu;
    ba = ctrl && ID_EX_RegWrite && !ID_EX_MemRead && (ID_EX_Rd != 5'd0) && match_ba;
    bl = ctrl && EX_MEM_MemRead && (EX_MEM_Rd != 5'd0) && match_bl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // HOLD1 is the second bubble a load needs ahead of a branch; the hazard is
  // known to persist, so it is not re-evaluated there.
  always_comb begin
    stall     = 1'b0;
    state_nxt = RUN;
    if (!rst) begin
      case (state)
        RUN: begin
          stall     = lu || ba || bl;
          state_nxt = (lu && ctrl) ? HOLD1 : RUN;
        end
        HOLD1: begin
          stall     = 1'b1;
          state_nxt = RUN;
        end
        default: begin
          stall     = 1'b0;
          state_nxt = RUN;
        end
      endcase
    end
  end

  // A stalled IF/ID is never flushed; the branch resolves again later.
  always_comb begin
    flush        = !rst && BranchTaken && !stall;
    PCWrite      = !stall;
    IF_ID_Write  = !stall;
    ID_EX_Bubble = stall;
    Stalling     = stall;
    IF_ID_Flush  = flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl

module tb_hazard_stall_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       IF_ID_Rs;
  logic [4:0]       IF_ID_Rt;
  logic             UsesRt;
  logic [3:0]       PCWriteCond;
  logic [1:0]       Jump;
  logic             BranchTaken;
  logic [4:0]       ID_EX_Rt;
  logic [4:0]       ID_EX_Rd;
  logic             ID_EX_MemRead;
  logic             ID_EX_RegWrite;
  logic [4:0]       EX_MEM_Rd;
  logic             EX_MEM_MemRead;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             ID_EX_Bubble;
  logic             IF_ID_Flush;
  logic             Stalling;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_assert;
  int n_fail;

  hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_ID_Rs       (IF_ID_Rs),
    .IF_ID_Rt       (IF_ID_Rt),
    .UsesRt         (UsesRt),
    .PCWriteCond    (PCWriteCond),
    .Jump           (Jump),
    .BranchTaken    (BranchTaken),
    .ID_EX_Rt       (ID_EX_Rt),
    .ID_EX_Rd       (ID_EX_Rd),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_RegWrite (ID_EX_RegWrite),
    .EX_MEM_Rd      (EX_MEM_Rd),
    .EX_MEM_MemRead (EX_MEM_MemRead),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .ID_EX_Bubble   (ID_EX_Bubble),
    .IF_ID_Flush    (IF_ID_Flush),
    .Stalling       (Stalling),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    IF_ID_Rs       = 5'd0;
    IF_ID_Rt       = 5'd0;
    UsesRt         = 1'b0;
    PCWriteCond    = 4'd0;
    Jump           = 2'd0;
    BranchTaken    = 1'b0;
    ID_EX_Rt       = 5'd0;
    ID_EX_Rd       = 5'd0;
    ID_EX_MemRead  = 1'b0;
    ID_EX_RegWrite = 1'b0;
    EX_MEM_Rd      = 5'd0;
    EX_MEM_MemRead = 1'b0;
  endtask

  // Checks the four stall-related outputs together for the expected stall value.
  task automatic chk_stall(input string tag, input logic exp_stall);
    chk({tag, ".stalling"}, Stalling, exp_stall);
    chk({tag, ".pcwrite"}, PCWrite, !exp_stall);
    chk({tag, ".ifid_write"}, IF_ID_Write, !exp_stall);
    chk({tag, ".bubble"}, ID_EX_Bubble, exp_stall);
  endtask

  // Advance one full clock: inputs are changed just after the falling edge,
  // outputs are sampled 1ns later, far from the rising edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_inputs();

    // Reset state.
    repeat (2) next_cycle();
    #1;
    chk_stall("reset", 1'b0);
    chk("reset.flush", IF_ID_Flush, 1'b0);
    chk("reset.stall_cnt", stall_cnt, 0);
    chk("reset.flush_cnt", flush_cnt, 0);
    rst = 1'b0;
    next_cycle();
    #1;
    chk_stall("idle", 1'b0);

    // Load-use, no control instruction: one stall cycle.
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5;
    #1;
    chk_stall("lu", 1'b1);
    next_cycle();
    clear_inputs();
    #1;
    chk_stall("lu.after", 1'b0);
    chk("lu.stall_cnt", stall_cnt, 1);

    // Load feeding a branch via rt: two stall cycles, second ignores inputs.
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; PCWriteCond = 4'h1;
    IF_ID_Rt = 5'd8; UsesRt = 1'b1;
    #1;
    chk_stall("lb.c1", 1'b1);
    next_cycle();
    clear_inputs();
    #1;
    chk_stall("lb.hold1", 1'b1);
    chk("lb.cnt1", stall_cnt, 2);
    next_cycle();
    #1;
    chk_stall("lb.after", 1'b0);
    chk("lb.stall_cnt", stall_cnt, 3);

    // ALU result into jump-register via rs: one stall.
    ID_EX_RegWrite = 1'b1; ID_EX_Rd = 5'd31; Jump = 2'b10; IF_ID_Rs = 5'd31;
    #1;
    chk_stall("jr", 1'b1);
    next_cycle();
    // Jump with rt match only: comparator ignores rt, no stall.
    IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd31; UsesRt = 1'b1;
    #1;
    chk_stall("jr.rt_only", 1'b0);
    chk("jr.stall_cnt", stall_cnt, 4);
    next_cycle();
    // Same rt match on a branch: BA via rt stalls.
    Jump = 2'b00; PCWriteCond = 4'h2;
    #1;
    chk_stall("ba.rt", 1'b1);
    next_cycle();
    // ALU result feeding a non-control instruction: forwarding covers it.
    clear_inputs();
    ID_EX_RegWrite = 1'b1; ID_EX_Rd = 5'd7; IF_ID_Rs = 5'd7;
    #1;
    chk_stall("alu.noctrl", 1'b0);
    chk("ba.stall_cnt", stall_cnt, 5);
    next_cycle();

    // Register zero never causes a hazard.
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
    #1;
    chk_stall("r0", 1'b0);
    next_cycle();
    // Taken branch alone flushes.
    clear_inputs();
    BranchTaken = 1'b1;
    #1;
    chk("flush.alone", IF_ID_Flush, 1'b1);
    chk_stall("flush.alone", 1'b0);
    next_cycle();
    clear_inputs();
    #1;
    chk("flush.cnt1", flush_cnt, 1);
    chk("flush.stall_cnt", stall_cnt, 5);

    // Load in MEM feeding branch rs with BranchTaken: stall wins, no flush.
    EX_MEM_MemRead = 1'b1; EX_MEM_Rd = 5'd4; PCWriteCond = 4'h1;
    IF_ID_Rs = 5'd4; BranchTaken = 1'b1;
    #1;
    chk_stall("bl", 1'b1);
    chk("bl.flush", IF_ID_Flush, 1'b0);
    next_cycle();
    clear_inputs();
    BranchTaken = 1'b1;
    #1;
    chk_stall("bl.after", 1'b0);
    chk("bl.flush_after", IF_ID_Flush, 1'b1);
    chk("bl.stall_cnt", stall_cnt, 6);
    chk("bl.flush_cnt_hold", flush_cnt, 1);
    next_cycle();
    clear_inputs();
    #1;
    chk("bl.flush_cnt", flush_cnt, 2);

    // Reset asserted asynchronously in the middle of HOLD1.
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd9; Jump = 2'b01; IF_ID_Rs = 5'd9;
    next_cycle();
    clear_inputs();
    #1;
    chk_stall("rh.hold1", 1'b1);
    chk("rh.cnt_before", stall_cnt, 7);
    #1;
    rst = 1'b1;
    #1;
    chk_stall("rh.async", 1'b0);
    chk("rh.stall_cnt", stall_cnt, 0);
    chk("rh.flush_cnt", flush_cnt, 0);
    // Hazard and taken branch presented while held in reset: ignored.
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5; BranchTaken = 1'b1;
    #1;
    chk_stall("rh.inrst", 1'b0);
    chk("rh.inrst_flush", IF_ID_Flush, 1'b0);
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk_stall("rh.run", 1'b0);
    chk("rh.cnt_held", stall_cnt, 0);

    // Saturation: continuous load-use for 20 cycles, counter stops at 15.
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd6; IF_ID_Rs = 5'd6;
    repeat (14) next_cycle();
    #1;
    chk("sat.cnt14", stall_cnt, 14);
    chk_stall("sat.still", 1'b1);
    repeat (6) next_cycle();
    #1;
    chk("sat.cnt_max", stall_cnt, 15);
    clear_inputs();
    next_cycle();
    #1;
    chk("sat.cnt_hold", stall_cnt, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- ID-stage hazard detector and stall sequencer.
- Sits directly upstream of the forwarding unit. It guarantees that every operand the forwarding unit must supply, to EX or to the ID-stage branch/jump comparator, is already in EX/MEM or MEM/WB when it is needed.
- Drives PC write enable, IF/ID write enable, ID/EX bubble insertion and IF/ID flush.
- Keeps saturating stall and flush event counters for performance analysis.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- IF_ID_Rs  input  5  rs field of the instruction in ID.
- IF_ID_Rt  input  5  rt field of the instruction in ID.
- UsesRt  input  1  instruction in ID reads rt as a source.
- PCWriteCond  input  4  branch condition code of the instruction in ID; nonzero means it is a branch.
- Jump  input  2  jump type of the instruction in ID; nonzero means a jump that reads rs.
- BranchTaken  input  1  ID-stage comparator resolved a taken branch or jump this cycle.
- ID_EX_Rt  input  5  load destination register in EX.
- ID_EX_Rd  input  5  ALU destination register in EX.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- ID_EX_RegWrite  input  1  instruction in EX writes the register file.
- EX_MEM_Rd  input  5  destination register in MEM.
- EX_MEM_MemRead  input  1  instruction in MEM is a load.
- PCWrite  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register update enable.
- ID_EX_Bubble  output  1  zero the ID/EX control fields.
- IF_ID_Flush  output  1  clear IF/ID to a NOP.
- Stalling  output  1  stall asserted this cycle.
- stall_cnt  output  CNT_W  number of stall cycles since reset; saturates.
- flush_cnt  output  CNT_W  number of flush cycles since reset; saturates.

Behaviour:
- Definitions:
  - ctrl = (PCWriteCond != 0) || (Jump != 0).
  - rdRs = (IF_ID_Rs != 0).
  - rdRt = UsesRt && (IF_ID_Rt != 0). For a jump with PCWriteCond == 0 the comparator reads rs only, so the rt match is ignored when ctrl is true and PCWriteCond == 0.
  - match(r) = (rdRs && r == IF_ID_Rs) || (rdRt && r == IF_ID_Rt).
- Hazard terms:
  - LU = ID_EX_MemRead && ID_EX_Rt != 0 && match(ID_EX_Rt).
  - BA = ctrl && ID_EX_RegWrite && !ID_EX_MemRead && ID_EX_Rd != 0 && match(ID_EX_Rd).
  - BL = ctrl && EX_MEM_MemRead && EX_MEM_Rd != 0 && match(EX_MEM_Rd).
- State machine: two states, RUN and HOLD1; reset state is RUN.
  - RUN: stall = LU || BA || BL. Next state is HOLD1 if LU && ctrl (a load feeding a branch needs 2 stalls), otherwise RUN.
  - HOLD1: stall = 1 unconditionally, with no hazard re-evaluation. Next state is RUN.
- Outputs (combinational from state and inputs):
  - When stalling: PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1, Stalling = 1.
  - Otherwise: PCWrite = 1, IF_ID_Write = 1, ID_EX_Bubble = 0, Stalling = 0.
  - IF_ID_Flush = BranchTaken && !stall. A stall takes priority: the branch resolves on a later cycle, and a flush is never issued against a stalled IF/ID.
- Counters:
  - stall_cnt increments by 1 on each rising edge where stall = 1.
  - flush_cnt increments by 1 on each rising edge where IF_ID_Flush = 1.
  - Both hold at all-ones and never wrap.
- Reset:
  - Asynchronous assertion forces state = RUN and both counters = 0 immediately, including mid-HOLD1.
  - While rst is high, outputs read PCWrite = 1, IF_ID_Write = 1, ID_EX_Bubble = 0, IF_ID_Flush = 0, Stalling = 0.
  - Deassertion takes effect at the next clock edge.
- Register 0 never causes a hazard.
- Simultaneous LU, BA and BL produce a single stall cycle in RUN, plus the HOLD1 cycle if LU && ctrl. Counters count cycles, not hazard terms.

Test Plan:
- Load-use: ID_EX_MemRead = 1, ID_EX_Rt = 5, IF_ID_Rs = 5, ctrl = 0 → exactly 1 cycle with PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1; stall_cnt goes 0 → 1; state stays RUN.
- Load then branch: ID_EX_MemRead = 1, ID_EX_Rt = 8, PCWriteCond = 4'h1, IF_ID_Rt = 8, UsesRt = 1 → stall in RUN then HOLD1 (2 cycles); stall_cnt = 2; the inputs in the second cycle are ignored.
- ALU result to jump-register: ID_EX_RegWrite = 1, ID_EX_Rd = 31, Jump = 2'b10, IF_ID_Rs = 31 → 1 stall. With IF_ID_Rt = 31 and Rs = 3, Jump only → no stall.
- Register zero: ID_EX_MemRead = 1, ID_EX_Rt = 0, IF_ID_Rs = 0 → no stall. Separately, BranchTaken = 1 alone → IF_ID_Flush = 1 and flush_cnt increments by 1.
- Stall and taken branch in the same cycle: BL hazard (EX_MEM_MemRead = 1, EX_MEM_Rd = 4, branch on rs = 4) with BranchTaken = 1 → IF_ID_Flush = 0 and the stall wins. Next cycle, hazard cleared and BranchTaken = 1 → flush = 1.
- Reset in HOLD1: assert rst asynchronously → state RUN, stall_cnt = 0, flush_cnt = 0, PCWrite = 1 without waiting for a clock. Preload stall_cnt to all-ones and stall again → value holds at 2^CNT_W − 1.
